// File: rtl/seg_decoder.sv
// seg_decoder: readback of an active-low seven-segment bus.
// Waits for the bus to hold steady for STABLE_CYCLES clocks.
// Then classifies the held pattern as a hex digit, blank, letter L or invalid.
// It keeps the decoded result and counts invalid patterns (saturating).
// Optional feature: define SEG_DECODE_LETTER_EN to decode 0x47 as letter L.
// Without it, 0x47 is classified as invalid.
module seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    output logic [3:0] val,
    output logic [1:0] kind,
    output logic       dp,
    output logic       upd,
    output logic [7:0] err_cnt
);

    typedef enum logic {
        WAIT = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] ACC_CNT  = 8'(STABLE_CYCLES - 1);
    localparam logic [1:0] K_HEX    = 2'b00;
    localparam logic [1:0] K_BLANK  = 2'b01;
    localparam logic [1:0] K_LETTER = 2'b10;
    localparam logic [1:0] K_INV    = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] s_q;
    logic [7:0] h_q;
    logic [7:0] cnt;
    logic       match;
    logic       accept;
    logic [5:0] dec;

    // Map segments a..g (dp excluded) to {kind, val}.
    function automatic logic [5:0] decode_seg(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'h40:   r = {K_HEX, 4'h0};
            7'h79:   r = {K_HEX, 4'h1};
            7'h24:   r = {K_HEX, 4'h2};
            7'h30:   r = {K_HEX, 4'h3};
            7'h19:   r = {K_HEX, 4'h4};
            7'h12:   r = {K_HEX, 4'h5};
            7'h02:   r = {K_HEX, 4'h6};
            7'h78:   r = {K_HEX, 4'h7};
            7'h00:   r = {K_HEX, 4'h8};
            7'h10:   r = {K_HEX, 4'h9};
            7'h08:   r = {K_HEX, 4'hA};
            7'h03:   r = {K_HEX, 4'hB};
            7'h46:   r = {K_HEX, 4'hC};
            7'h21:   r = {K_HEX, 4'hD};
            7'h06:   r = {K_HEX, 4'hE};
            7'h0E:   r = {K_HEX, 4'hF};
            7'h7F:   r = {K_BLANK, 4'h0};
`ifdef SEG_DECODE_LETTER_EN
            7'h47:   r = {K_LETTER, 4'h0};
`endif
            default: r = {K_INV, 4'h0};
        endcase
        return r;
    endfunction

    // The bus is compared against the previous sample.
    // An accept always loads the current sample.
    assign match = (seg_in == s_q);
    assign dec   = decode_seg(s_q[6:0]);

    // Sample register and saturating run-length counter of matching samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= 8'hFF;
            cnt <= 8'h00;
        end else begin
            s_q <= seg_in;
            if (!match) begin
                cnt <= 8'h00;
            end else if (cnt != 8'hFF) begin
                cnt <= cnt + 8'h01;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state.
    // HOLD blocks re-accepting a run that was already accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:    if (accept) state_nxt = HOLD;
            HOLD:    if (!match) state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    // FSM output: accept fires once per stable run, when the window fills.
    always_comb begin
        accept = 1'b0;
        if (state == WAIT && match && cnt == ACC_CNT) begin
            accept = 1'b1;
        end
    end

    // Held pattern, decoded outputs, change pulse and invalid counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q     <= 8'hFF;
            val     <= 4'h0;
            kind    <= K_BLANK;
            dp      <= 1'b0;
            upd     <= 1'b0;
            err_cnt <= 8'h00;
        end else begin
            upd <= 1'b0;
            if (accept) begin
                h_q  <= s_q;
                val  <= dec[3:0];
                kind <= dec[5:4];
                dp   <= ~s_q[7];
                upd  <= (s_q != h_q);
                if (dec[5:4] == K_INV && err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'h01;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_decoder.sv
// Testbench for seg_decoder.
// Two instances are built, with STABLE_CYCLES = 4 and STABLE_CYCLES = 1.
// Both are compared every cycle against a run-length reference model.
module tb_seg_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg_in;
    logic [3:0] val_o   [2];
    logic [1:0] kind_o  [2];
    logic       dp_o    [2];
    logic       upd_o   [2];
    logic [7:0] err_o   [2];

    int n_chk  = 0;
    int n_fail = 0;
    int n_cyc  = 0;

    always #5 clk = ~clk;

    seg_decoder #(.STABLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
        .val(val_o[0]), .kind(kind_o[0]), .dp(dp_o[0]), .upd(upd_o[0]), .err_cnt(err_o[0])
    );

    seg_decoder #(.STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
        .val(val_o[1]), .kind(kind_o[1]), .dp(dp_o[1]), .upd(upd_o[1]), .err_cnt(err_o[1])
    );

    // Reference model state.
    // Each run of identical samples is accepted once, when its length reaches STABLE+1.
    // The reset value 0xFF counts as the first sample of a run.
    localparam logic [6:0] HEX_PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int         m_stable [2] = '{4, 1};
    int         m_run    [2];
    logic [7:0] m_last   [2];
    logic [7:0] m_held   [2];
    logic [3:0] m_val    [2];
    logic [1:0] m_kind   [2];
    logic       m_dp     [2];
    logic       m_upd    [2];
    int         m_err    [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ref_class(input logic [7:0] p);
        for (int i = 0; i < 16; i++) begin
            if (p[6:0] == HEX_PAT[i]) return {2'b00, 4'(i)};
        end
        if (p[6:0] == 7'h7F) return {2'b01, 4'h0};
`ifdef SEG_DECODE_LETTER_EN
        if (p[6:0] == 7'h47) return {2'b10, 4'h0};
`endif
        return {2'b11, 4'h0};
    endfunction

    task automatic model_edge();
        logic [5:0] c;
        for (int i = 0; i < 2; i++) begin
            m_upd[i] = 1'b0;
            if (!rst_n) begin
                m_run[i]  = 1;
                m_last[i] = 8'hFF;
                m_held[i] = 8'hFF;
                m_val[i]  = 4'h0;
                m_kind[i] = 2'b01;
                m_dp[i]   = 1'b0;
                m_err[i]  = 0;
            end else begin
                if (seg_in == m_last[i]) m_run[i]++;
                else m_run[i] = 1;
                m_last[i] = seg_in;
                if (m_run[i] == m_stable[i] + 1) begin
                    c = ref_class(seg_in);
                    m_upd[i]  = (seg_in != m_held[i]);
                    m_held[i] = seg_in;
                    m_kind[i] = c[5:4];
                    m_val[i]  = c[3:0];
                    m_dp[i]   = ~seg_in[7];
                    if (c[5:4] == 2'b11 && m_err[i] < 255) m_err[i]++;
                end
            end
        end
    endtask

    // Drive one value, take one rising edge, and compare both instances after the edge.
    task automatic cyc(input logic [7:0] v);
        seg_in = v;
        @(posedge clk);
        model_edge();
        #1;
        n_cyc++;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cyc%0d_inst%0d {val,kind,dp,upd,err}", n_cyc, i),
                {16'h0, val_o[i], kind_o[i], dp_o[i], upd_o[i], err_o[i]},
                {16'h0, m_val[i], m_kind[i], m_dp[i], m_upd[i], 8'(m_err[i])});
        end
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) cyc(v);
    endtask

    logic [7:0] v;
    int         len;

    initial begin
        rst_n  = 1'b0;
        seg_in = 8'hFF;
        cyc(8'hFF);
        cyc(8'hFF);
        chk("reset_val",  val_o[0],  4'h0);
        chk("reset_kind", kind_o[0], 2'b01);
        chk("reset_dp",   dp_o[0],   1'b0);
        chk("reset_upd",  upd_o[0],  1'b0);
        chk("reset_err",  err_o[0],  8'h00);
        rst_n = 1'b1;

        // 0x24 sampled first at edge k; outputs change after edge k+4.
        for (int i = 1; i <= 6; i++) begin
            cyc(8'h24);
            if (i == 4) begin
                chk("t1_pre_kind", kind_o[0], 2'b01);
                chk("t1_pre_upd",  upd_o[0],  1'b0);
            end
            if (i == 5) begin
                chk("t1_val",  val_o[0],  4'h2);
                chk("t1_kind", kind_o[0], 2'b00);
                chk("t1_upd",  upd_o[0],  1'b1);
            end
            if (i == 6) chk("t1_upd_low", upd_o[0], 1'b0);
        end

        // A short glitch, then a return to the held pattern.
        hold(8'h79, 3);
        hold(8'h24, 6);
        chk("t2_val", val_o[0], 4'h2);
        chk("t2_err", err_o[0], 8'h00);

        // Same digit; the decimal point goes on, then off.
        hold(8'h0E, 6);
        chk("t3_dp_on", dp_o[0], 1'b1);
        hold(8'h8E, 6);
        chk("t3_val", val_o[0], 4'hF);
        chk("t3_dp_off", dp_o[0], 1'b0);

        // Letter L pattern.
        hold(8'h47, 6);
`ifdef SEG_DECODE_LETTER_EN
        chk("t4_kind", kind_o[0], 2'b10);
        chk("t4_err",  err_o[0],  8'h00);
`else
        chk("t4_kind", kind_o[0], 2'b11);
        chk("t4_err",  err_o[0],  8'h01);
`endif

        // Reset mid-window discards the partial run.
        hold(8'h40, 2);
        rst_n = 1'b0;
        cyc(8'h40);
        rst_n = 1'b1;
        chk("t6_rst_kind", kind_o[0], 2'b01);
        chk("t6_rst_err",  err_o[0],  8'h00);
        for (int i = 1; i <= 5; i++) begin
            cyc(8'h40);
            if (i == 4) chk("t6_pre_kind", kind_o[0], 2'b01);
            if (i == 5) begin
                chk("t6_kind", kind_o[0], 2'b00);
                chk("t6_upd",  upd_o[0],  1'b1);
            end
        end

        // Blank present at reset release: accepted with no change pulse.
        rst_n = 1'b0;
        cyc(8'hFF);
        rst_n = 1'b1;
        hold(8'hFF, 6);

        // Randomized bursts with occasional resets.
        for (int b = 0; b < 400; b++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: v = {1'($urandom), HEX_PAT[$urandom_range(0, 15)]};
                3:       v = {1'($urandom), 7'h7F};
                4:       v = {1'($urandom), 7'h47};
                default: v = 8'($urandom);
            endcase
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                cyc(v);
                rst_n = 1'b1;
            end
            hold(v, len);
        end

        // Invalid/blank alternation drives the error counter into saturation.
        for (int i = 0; i < 300; i++) begin
            hold(8'h55, 5);
            if (i == 299) chk("t5_kind_inv", kind_o[0], 2'b11);
            hold(8'h7F, 5);
        end
        chk("t5_kind_blank", kind_o[0], 2'b01);
        chk("t5_err_sat4",   err_o[0],  8'hFF);
        chk("t5_err_sat1",   err_o[1],  8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
